// File: rtl/demux8_deser_pkg.sv
// Shared constants and state encoding for the demux8_deser 1-to-8 deserializer.
package demux8_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam logic [LANES-1:0] FULL_MASK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/demux8_deser_if.sv
// Input/output handshake bundle for demux8_deser.
// Optional flush/lane_mask signals exist only when DEMUX8_FLUSH_EN is defined.
interface demux8_deser_if
  import demux8_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [LANES-1:0]       lane_strobe;
  logic [LANES*WIDTH-1:0] data_out;
  logic                   out_valid;
  logic                   out_ready;
`ifdef DEMUX8_FLUSH_EN
  logic                   flush;
  logic [LANES-1:0]       lane_mask;

  modport master (
    output in_data, in_valid, mode, sel, out_ready, flush,
    input  in_ready, lane_strobe, data_out, out_valid, lane_mask
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready, flush,
    output in_ready, lane_strobe, data_out, out_valid, lane_mask
  );
`else
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, lane_strobe, data_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, lane_strobe, data_out, out_valid
  );
`endif

endinterface

// File: rtl/demux8_deser_dec3_8.sv
// Combinational 3-to-8 one-hot decoder producing lane write enables.
module dec3_8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // Decode lane index to one-hot enable
  always_comb begin
    onehot = 8'h00;
    case (sel)
      3'd0:    onehot = 8'h01;
      3'd1:    onehot = 8'h02;
      3'd2:    onehot = 8'h04;
      3'd3:    onehot = 8'h08;
      3'd4:    onehot = 8'h10;
      3'd5:    onehot = 8'h20;
      3'd6:    onehot = 8'h40;
      3'd7:    onehot = 8'h80;
      default: onehot = 8'h00;
    endcase
  end

endmodule

// File: rtl/demux8_deser.sv
// 1-to-8 registered demultiplexer/deserializer: fills 8 lanes (auto sweep or addressed) and
// presents the frame on a valid/ready output. Optional flush build: DEMUX8_FLUSH_EN.
module demux8_deser
  import demux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  demux8_deser_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic                   mode_q_r;
  logic [SEL_W-1:0]       ptr_r;
  logic [LANES-1:0]       mask_r;
  logic [LANES-1:0]       mask_nxt_s;
  logic [LANES-1:0]       strobe_r;
  logic [LANES*WIDTH-1:0] data_r;
  logic                   in_ready_r;
  logic                   out_valid_r;

  logic                   accept_s;
  logic                   release_s;
  logic                   eff_mode_s;
  logic                   done_s;
  logic                   flush_s;
  logic [SEL_W-1:0]       lane_sel_s;
  logic [LANES-1:0]       dec_s;
  logic [LANES-1:0]       we_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign release_s = (state_r == ST_HOLD) & bus.out_ready;

  // Mode is taken live only for the first item of a frame, then frozen in mode_q_r
  always_comb begin
    if (state_r == ST_IDLE) begin
      eff_mode_s = bus.mode;
    end else begin
      eff_mode_s = mode_q_r;
    end
    if (eff_mode_s) begin
      lane_sel_s = bus.sel;
    end else begin
      lane_sel_s = ptr_r;
    end
  end

  dec3_8 u_dec (
    .sel    (lane_sel_s),
    .onehot (dec_s)
  );

  // Write enables, written-lane mask and frame-completion detection
  always_comb begin
    if (accept_s) begin
      we_s = dec_s;
    end else begin
      we_s = {LANES{1'b0}};
    end
    mask_nxt_s = mask_r | we_s;
    if (!accept_s) begin
      done_s = 1'b0;
    end else if (eff_mode_s) begin
      done_s = (mask_nxt_s == FULL_MASK);
    end else begin
      done_s = (ptr_r == 3'd7);
    end
`ifdef DEMUX8_FLUSH_EN
    flush_s = bus.flush & (state_r == ST_FILL);
`else
    flush_s = 1'b0;
`endif
  end

  // Next-state logic; the first accept can never complete a frame, so IDLE always goes to FILL
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_FILL;
        else          state_nxt_s = ST_IDLE;
      end
      ST_FILL: begin
        if (done_s || flush_s) state_nxt_s = ST_HOLD;
        else                   state_nxt_s = ST_FILL;
      end
      ST_HOLD: begin
        if (bus.out_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, pointer, mask and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_q_r    <= 1'b0;
      ptr_r       <= 3'd0;
      mask_r      <= {LANES{1'b0}};
      strobe_r    <= {LANES{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      strobe_r    <= we_s;
      in_ready_r  <= (state_nxt_s != ST_HOLD);
      out_valid_r <= (state_nxt_s == ST_HOLD);
      if ((state_r == ST_IDLE) && accept_s) begin
        mode_q_r <= bus.mode;
      end else begin
        mode_q_r <= mode_q_r;
      end
      if (release_s) begin
        ptr_r  <= 3'd0;
        mask_r <= {LANES{1'b0}};
      end else begin
        mask_r <= mask_nxt_s;
        if (accept_s && !eff_mode_s) ptr_r <= ptr_r + 3'd1;
        else                         ptr_r <= ptr_r;
      end
    end
  end

  // Lane data; a flushed frame zeroes lanes not written in this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {(LANES*WIDTH){1'b0}};
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (we_s[k]) begin
          data_r[k*WIDTH +: WIDTH] <= bus.in_data;
        end else if (flush_s && !mask_nxt_s[k]) begin
          data_r[k*WIDTH +: WIDTH] <= {WIDTH{1'b0}};
        end else begin
          data_r[k*WIDTH +: WIDTH] <= data_r[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.lane_strobe = strobe_r;
  assign bus.data_out    = data_r;
`ifdef DEMUX8_FLUSH_EN
  assign bus.lane_mask   = mask_r;
`endif

endmodule

// File: tb/tb_demux8_deser.sv
// Directed + randomized bench for demux8_deser (WIDTH=4) against a lane-array reference model.
module tb_demux8_deser;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // reference model: frame-level view of the lanes
  logic [W-1:0] m_lanes [8];
  logic [7:0]   m_written;
  logic         m_active;
  logic         m_mode;
  int           m_cnt;
  logic         m_done;

  demux8_deser_if #(.WIDTH(W)) bus ();

  demux8_deser #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*W-1:0] model_word();
    logic [8*W-1:0] w;
    for (int k = 0; k < 8; k++) w[k*W +: W] = m_lanes[k];
    return w;
  endfunction

  function automatic logic [7:0] bit0_view(input logic [8*W-1:0] d);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = d[k*W];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_lanes[k] = '0;
    m_written = 8'h00;
    m_active  = 1'b0;
    m_mode    = 1'b0;
    m_cnt     = 0;
    m_done    = 1'b0;
  endtask

  // one accepted item: wait for ready (bounded), clock it in, compare against the model
  task automatic push(input logic [W-1:0] d, input logic [2:0] s);
    int n;
    int lane;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sel      = s;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    if (!m_active) begin
      m_active  = 1'b1;
      m_mode    = bus.mode;
      m_cnt     = 0;
      m_written = 8'h00;
    end
    lane = m_mode ? int'(s) : m_cnt;
    m_lanes[lane]   = d;
    m_written[lane] = 1'b1;
    m_cnt++;
    m_done = m_mode ? (m_written == 8'hFF) : (m_cnt == 8);
    tick();
    bus.in_valid = 1'b0;
    check("lane_strobe", {56'd0, bus.lane_strobe}, 64'd1 << lane);
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_done});
    check("in_ready_after", {63'd0, bus.in_ready}, {63'd0, !m_done});
`ifdef DEMUX8_FLUSH_EN
    check("lane_mask", {56'd0, bus.lane_mask}, {56'd0, m_written});
`endif
    if (m_done) check("data_out", {32'd0, bus.data_out}, {32'd0, model_word()});
  endtask

  task automatic release_frame();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    m_active  = 1'b0;
    m_done    = 1'b0;
    m_written = 8'h00;
    check("rel_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rel_strobe", {56'd0, bus.lane_strobe}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_strobe", {56'd0, bus.lane_strobe}, 64'd0);
    check("rst_data_out", {32'd0, bus.data_out}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    logic [7:0]     auto_bits;
    logic [8*W-1:0] held;
    int             guard;

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 3'd0;
    bus.out_ready = 1'b0;
`ifdef DEMUX8_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    model_reset();
    #1;
    do_reset();

    // auto frame: bits 1,0,1,1,0,0,1,0 into lanes 0..7
    auto_bits = 8'b0100_1101;
    bus.mode = 1'b0;
    for (int i = 0; i < 8; i++) push({3'd0, auto_bits[i]}, 3'd0);
    check("auto_bit0_word", {56'd0, bit0_view(bus.data_out)}, 64'h4D);

    // backpressure: valid held high while frame is held
    held = bus.data_out;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_data_out", {32'd0, bus.data_out}, {32'd0, held});
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    m_active = 1'b0;
    m_done   = 1'b0;
    check("bp_rel_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("bp_rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("bp_rel_strobe", {56'd0, bus.lane_strobe}, 64'd0);
    // new frame must restart at lane 0 (push checks strobe 8'h01)
    push(4'h9, 3'd0);
    for (int i = 1; i < 8; i++) push(4'(i), 3'd0);
    release_frame();

    // addressed frame: sel 7..0 carrying data 7..0, mode toggled mid-frame
    bus.mode = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      push(4'(i), 3'(i));
      bus.mode = ~bus.mode;
    end
    check("addr_word", {32'd0, bus.data_out}, 64'h76543210);
    release_frame();

    // addressed duplicate: lane 3 written A then B
    bus.mode = 1'b1;
    push(4'hA, 3'd3);
    push(4'hB, 3'd3);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) push(4'(i + 1), 3'(i));
    end
    check("dup_lane3", {60'd0, bus.data_out[3*W +: W]}, 64'hB);
    release_frame();

    // reset mid-frame after 4 auto accepts
    bus.mode = 1'b0;
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 3'd0);
    do_reset();
    for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 3'd0);
    release_frame();

`ifdef DEMUX8_FLUSH_EN
    // flush after 3 auto items: unwritten lanes read zero
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) push(4'h1, 3'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int k = 0; k < 8; k++) if (!m_written[k]) m_lanes[k] = '0;
    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("flush_word", {32'd0, bus.data_out}, 64'h00000111);
    check("flush_bit0", {56'd0, bit0_view(bus.data_out)}, 64'h07);
    check("flush_lane_mask", {56'd0, bus.lane_mask}, 64'h07);
    release_frame();
`endif

    // randomized frames with random mode, gaps, sel, and hold time
    for (int f = 0; f < 10; f++) begin
      bus.mode = 1'($urandom_range(0, 1));
      guard = 0;
      do begin
        push(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        bus.mode = 1'($urandom_range(0, 1));
        for (int g = 0; g < int'($urandom_range(0, 2)) && !m_done; g++) begin
          tick();
          check("gap_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        guard++;
      end while (!m_done && guard < 80);
      check("rand_frame_done", {63'd0, m_done}, 64'd1);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        tick();
        check("rand_hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("rand_hold_data", {32'd0, bus.data_out}, {32'd0, model_word()});
      end
      release_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
